// File: rtl/uart_rx_word_loader_pkg.sv
// rtl/uart_rx_word_loader_pkg.sv - shared UART word loader state encodings, debug layout and lane helper
package uart_rx_word_loader_pkg;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_PUSH    = 2'd1
  } loader_state_e;

  localparam int DBG_W         = 16;
  localparam int DBG_WORDS_LSB = 0;
  localparam int DBG_COUNT_LSB = 8;
  localparam int DBG_IDX_LSB   = 12;
  localparam int DBG_STATE_LSB = 14;

  // Little-endian puts byte idx in lane idx; big-endian mirrors the lane.
  function automatic logic [31:0] put_lane(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b, input logic big);
    logic [31:0] r;
    logic [1:0]  lane;
    r    = w;
    lane = big ? ~idx : idx;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, mid-bit sampling, one-cycle rx_ready pulse with framing flag
module uart_rx #(
  parameter int CLK_PER_HALF_BIT = 217
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd_i,
  output logic [7:0] rdata_o,
  output logic       rx_ready_o,
  output logic       ferr_o
);

  localparam int CW = $clog2(2 * CLK_PER_HALF_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(2 * CLK_PER_HALF_BIT - 1);

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP,
    R_WAIT_HIGH
  } rx_state_e;

  rx_state_e     state_q, state_d;
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          ready_q, ready_d;
  logic          ferr_q, ferr_d;
  logic          rxd_s;

  assign rxd_s      = sync_q[1];
  assign rdata_o    = rdata_q;
  assign rx_ready_o = ready_q;
  assign ferr_o     = ferr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= 2'b11;
      state_q <= R_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rxd_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    ferr_d  = ferr_q;
    case (state_q)
      R_IDLE: begin
        cnt_d = '0;
        if (!rxd_s) state_d = R_START;
      end
      R_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxd_s ? R_IDLE : R_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = R_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          ready_d = 1'b1;
          ferr_d  = !rxd_s;
          rdata_d = shift_q;
          // A low stop bit leaves the line low; wait for it to recover before hunting a start bit.
          state_d = rxd_s ? R_IDLE : R_WAIT_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_WAIT_HIGH: begin
        if (rxd_s) state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_word_fifo.sv
// rtl/uart_word_fifo.sv - synchronous show-ahead word FIFO; push at full is accepted only with a same-cycle pop
module uart_word_fifo #(
  parameter int AW = 3,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_word_loader.sv
// rtl/uart_rx_word_loader.sv - packs UART bytes into 32-bit words and buffers them for the core
module uart_rx_word_loader
  import uart_rx_word_loader_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 217,
  parameter int FIFO_AW          = 3,
  parameter int BIG_ENDIAN       = 0,
  parameter int TIMEOUT_CYC      = 65536
) (
  input  logic             clk,
  input  logic             rstn_uart,
  input  logic             rxd,
  output logic [31:0]      word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             frame_err,
  output logic             overflow,
  input  logic             clr_err,
  output logic [DBG_W-1:0] debug
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic BE = (BIG_ENDIAN != 0);

  loader_state_e state_q, state_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   word_q, word_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    words_q;
  logic          frame_err_q, overflow_q;

  logic [7:0]    rx_data;
  logic          rx_ready, rx_ferr;
  logic          push, push_ok, pop;
  logic          frame_set, ovf_set;
  logic          fifo_full, fifo_empty;
  logic [FIFO_AW:0] fifo_count;
  logic [3:0]    count4;

  uart_rx #(
    .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
  ) u_rx (
    .clk       (clk),
    .rstn      (rstn_uart),
    .rxd_i     (rxd),
    .rdata_o   (rx_data),
    .rx_ready_o(rx_ready),
    .ferr_o    (rx_ferr)
  );

  uart_word_fifo #(
    .AW(FIFO_AW),
    .DW(32)
  ) u_fifo (
    .clk    (clk),
    .rstn   (rstn_uart),
    .push_i (push),
    .wdata_i(word_q),
    .pop_i  (pop),
    .rdata_o(word_out),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  assign word_valid = !fifo_empty;
  assign pop        = word_valid && word_ready;
  assign push_ok    = push && (!fifo_full || pop);
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;
  assign count4     = 4'(fifo_count);

  always_ff @(posedge clk or negedge rstn_uart) begin
    if (!rstn_uart) begin
      state_q     <= S_COLLECT;
      byte_idx_q  <= '0;
      word_q      <= '0;
      timer_q     <= '0;
      words_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      timer_q     <= timer_d;
      if (push_ok) words_q <= words_q + 8'd1;
      // A flag being set this cycle beats a simultaneous clear.
      frame_err_q <= frame_set | (frame_err_q & ~clr_err);
      overflow_q  <= ovf_set | (overflow_q & ~clr_err);
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    timer_d    = timer_q;
    push       = 1'b0;
    frame_set  = 1'b0;
    ovf_set    = 1'b0;

    if (rx_ready) begin
      timer_d = '0;
      if (rx_ferr) begin
        byte_idx_d = '0;
        frame_set  = 1'b1;
      end else begin
        word_d     = put_lane(word_q, byte_idx_q, rx_data, BE);
        byte_idx_d = byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd3) state_d = S_PUSH;
      end
    end else if (byte_idx_q != 2'd0) begin
      // A stalled partial word is silently abandoned so the next byte starts a fresh word.
      if (timer_q == TO_LAST) begin
        timer_d    = '0;
        byte_idx_d = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end else begin
      timer_d = '0;
    end

    if (state_q == S_PUSH) begin
      state_d = S_COLLECT;
      push    = 1'b1;
      if (fifo_full && !pop) ovf_set = 1'b1;
    end
  end

  always_comb begin
    debug = '0;
    debug[DBG_STATE_LSB +: 2] = state_q;
    debug[DBG_IDX_LSB   +: 2] = byte_idx_q;
    debug[DBG_COUNT_LSB +: 4] = count4;
    debug[DBG_WORDS_LSB +: 8] = words_q;
  end

endmodule
